// File: rtl/eda_regional_max_pkg.sv
// Shared types and helpers for the eda_regional_max front-end sequencer.
package eda_regional_max_pkg;

    // Default image geometry and pixel width.
    localparam int DEF_M           = 6;
    localparam int DEF_N           = 6;
    localparam int DEF_PIXEL_WIDTH = 8;

    // Scheduler states, in frame order.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CLEAR = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

    // Core address is the plain concatenation {i,j}, not i*N+j.
    // Callers cast the result down to their own address width.
    function automatic logic [15:0] make_addr(
        input logic [7:0] i,
        input logic [7:0] j,
        input int         j_width
    );
        return (16'(i) << j_width) | 16'(j);
    endfunction

endpackage

// File: rtl/eda_raster_counter.sv
// Row/column position counter walking an M x N image in raster order.
// Exposes the current position, the position after this edge, and a flag
// for the last pixel (M-1,N-1). clr has priority over inc.
module eda_raster_counter
    import eda_regional_max_pkg::*;
#(
    parameter int M       = DEF_M,
    parameter int N       = DEF_N,
    parameter int I_WIDTH = $clog2(M),
    parameter int J_WIDTH = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [I_WIDTH-1:0] i_o,
    output logic [J_WIDTH-1:0] j_o,
    output logic [I_WIDTH-1:0] nxt_i_o,
    output logic [J_WIDTH-1:0] nxt_j_o,
    output logic               last_o
);

    localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(M - 1);
    localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N - 1);

    logic [I_WIDTH-1:0] i_q, i_d;
    logic [J_WIDTH-1:0] j_q, j_d;

    // Next position: zero on clear, otherwise step j and carry into i.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clr_i) begin
            i_d = '0;
            j_d = '0;
        end else if (inc_i) begin
            if (j_q == J_LAST) begin
                j_d = '0;
                if (i_q == I_LAST) begin
                    i_d = '0;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign i_o     = i_q;
    assign j_o     = j_q;
    assign nxt_i_o = i_d;
    assign nxt_j_o = j_d;
    assign last_o  = (i_q == I_LAST) && (j_q == J_LAST);

endmodule

// File: rtl/eda_pixel_scheduler.sv
// Front-end sequencer for eda_regional_max: loads a raster frame into the
// core image RAM, then issues every center in raster order, waiting for the
// core (or a timeout) between centers, and finishes with clear/frame_done.
module eda_pixel_scheduler
    import eda_regional_max_pkg::*;
#(
    parameter int M           = DEF_M,
    parameter int N           = DEF_N,
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int I_WIDTH     = $clog2(M),
    parameter int J_WIDTH     = $clog2(N),
    parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH,
    parameter int TIMEOUT     = 64,
    parameter int TO_WIDTH    = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   s_valid,
    input  logic [PIXEL_WIDTH-1:0] s_pixel,
    output logic                   s_ready,
    input  logic                   abort,
    input  logic                   core_done,
    output logic                   write_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [PIXEL_WIDTH-1:0] pixel_in,
    output logic [ADDR_WIDTH-1:0]  center_addr,
    output logic                   new_pixel,
    output logic                   clear,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   timeout_err
);

    // Timeout counter needs at least one bit even when the timeout is off.
    localparam int TW = (TO_WIDTH > 0) ? TO_WIDTH : 1;

    sched_state_t state_q, state_d;

    logic accept;
    logic active;
    logic abort_act;
    logic advance;
    logic timeout_hit;
    logic cnt_clr;

    logic [I_WIDTH-1:0] li, ci, li_nxt, ci_nxt;
    logic [J_WIDTH-1:0] lj, cj, lj_nxt, cj_nxt;
    logic               load_last, scan_last;

    logic [TW-1:0]          to_q, to_d;
    logic                   write_en_q, write_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [PIXEL_WIDTH-1:0] pixel_in_q, pixel_in_d;
    logic [ADDR_WIDTH-1:0]  center_addr_q, center_addr_d;
    logic                   new_pixel_q, new_pixel_d;
    logic                   clear_q, clear_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   timeout_err_q, timeout_err_d;

    // Abort only matters while a frame is being loaded or scanned.
    assign active    = (state_q == ST_LOAD) || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign abort_act = abort && active;

    // s_ready is the only combinational output; it is forced low during reset.
    assign s_ready = reset_n && ((state_q == ST_IDLE) || (state_q == ST_LOAD));

    // A beat that coincides with an abort is discarded.
    assign accept = s_valid && s_ready && !abort_act;

    // A center is finished either by the core or by the watchdog.
    assign advance = (state_q == ST_WAIT) && !abort && (core_done || timeout_hit);

    // Both position counters return to the origin on abort and at frame end.
    assign cnt_clr = abort_act || (state_q == ST_CLEAR);

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign timeout_hit = (state_q == ST_WAIT) && (to_q == TW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Load position: where the next accepted pixel is written.
    eda_raster_counter #(
        .M       (M),
        .N       (N),
        .I_WIDTH (I_WIDTH),
        .J_WIDTH (J_WIDTH)
    ) u_load_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (cnt_clr),
        .inc_i   (accept),
        .i_o     (li),
        .j_o     (lj),
        .nxt_i_o (li_nxt),
        .nxt_j_o (lj_nxt),
        .last_o  (load_last)
    );

    // Scan position: the center currently handed to the core.
    eda_raster_counter #(
        .M       (M),
        .N       (N),
        .I_WIDTH (I_WIDTH),
        .J_WIDTH (J_WIDTH)
    ) u_scan_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (cnt_clr),
        .inc_i   (advance),
        .i_o     (ci),
        .j_o     (cj),
        .nxt_i_o (ci_nxt),
        .nxt_j_o (cj_nxt),
        .last_o  (scan_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything in the active states.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = load_last ? ST_ISSUE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else if (accept && load_last) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = abort ? ST_CLEAR : ST_WAIT;
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else if (advance) begin
                    state_d = scan_last ? ST_CLEAR : ST_ISSUE;
                end
            end
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output next-values; the strobes follow state_d so they line up with the
    // state they belong to once registered.
    always_comb begin
        write_en_d    = accept;
        wr_addr_d     = wr_addr_q;
        pixel_in_d    = pixel_in_q;
        center_addr_d = center_addr_q;
        new_pixel_d   = (state_d == ST_ISSUE);
        clear_d       = (state_d == ST_CLEAR);
        frame_done_d  = (state_d == ST_DONE);
        busy_d        = (state_d != ST_IDLE);
        timeout_err_d = timeout_err_q;
        to_d          = (state_q == ST_WAIT) ? to_q + 1'b1 : '0;

        if (accept) begin
            wr_addr_d  = ADDR_WIDTH'(make_addr(8'(li), 8'(lj), J_WIDTH));
            pixel_in_d = s_pixel;
        end

        // Entering ISSUE: present the position the scan counter moves to now.
        if (state_d == ST_ISSUE) begin
            center_addr_d = ADDR_WIDTH'(make_addr(8'(ci_nxt), 8'(cj_nxt), J_WIDTH));
        end

        // The error flag lives across frames until the next first beat.
        // A core_done arriving on the timeout cycle wins.
        if ((state_q == ST_IDLE) && accept) begin
            timeout_err_d = 1'b0;
        end else if (timeout_hit && !core_done && !abort) begin
            timeout_err_d = 1'b1;
        end
    end

    // Output and watchdog registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            write_en_q    <= 1'b0;
            wr_addr_q     <= '0;
            pixel_in_q    <= '0;
            center_addr_q <= '0;
            new_pixel_q   <= 1'b0;
            clear_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            to_q          <= '0;
        end else begin
            write_en_q    <= write_en_d;
            wr_addr_q     <= wr_addr_d;
            pixel_in_q    <= pixel_in_d;
            center_addr_q <= center_addr_d;
            new_pixel_q   <= new_pixel_d;
            clear_q       <= clear_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
            to_q          <= to_d;
        end
    end

    assign write_en    = write_en_q;
    assign wr_addr     = wr_addr_q;
    assign pixel_in    = pixel_in_q;
    assign center_addr = center_addr_q;
    assign new_pixel   = new_pixel_q;
    assign clear       = clear_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_eda_pixel_scheduler.sv
// Scoreboard bench for eda_pixel_scheduler: stimulus pushes expected writes,
// centers and frame ends into queues; a monitor pops and compares them.
module tb_eda_pixel_scheduler;

    localparam int M       = 6;
    localparam int N       = 6;
    localparam int PW      = 8;
    localparam int IW      = 3;
    localparam int JW      = 3;
    localparam int AW      = 6;
    localparam int TIMEOUT = 64;
    localparam int TOW     = 7;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_valid = 1'b0;
    logic [PW-1:0] s_pixel = '0;
    logic          s_ready;
    logic          abort = 1'b0;
    logic          core_done;
    logic          model_done = 1'b0;
    logic          stray_done = 1'b0;
    logic          write_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] pixel_in;
    logic [AW-1:0] center_addr;
    logic          new_pixel;
    logic          clear;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;

    assign core_done = model_done | stray_done;

    eda_pixel_scheduler #(
        .M(M), .N(N), .PIXEL_WIDTH(PW), .I_WIDTH(IW), .J_WIDTH(JW),
        .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT), .TO_WIDTH(TOW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_pixel(s_pixel),
        .s_ready(s_ready), .abort(abort), .core_done(core_done),
        .write_en(write_en), .wr_addr(wr_addr), .pixel_in(pixel_in),
        .center_addr(center_addr), .new_pixel(new_pixel), .clear(clear),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] addr; logic [PW-1:0] data; } wr_exp_t;
    typedef struct packed { logic [AW-1:0] addr; logic terr; } np_exp_t;

    wr_exp_t wr_q[$];
    np_exp_t np_q[$];
    logic    fr_q[$];

    int checks = 0;
    int passes = 0;
    int frames_seen = 0;
    int cyc = 0;

    logic          silent_en = 1'b0;
    logic [AW-1:0] silent_addr = 6'o32;   // center {3,2}

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Core model: answer 3 cycles after each new_pixel, except the silent center.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) model_done = 1'b1;
            end
            if (new_pixel && !(silent_en && center_addr == silent_addr)) cnt = 3;
        end
    end

    // Monitor: compare every DUT output event against the scoreboard.
    initial begin
        wr_exp_t       we;
        np_exp_t       ne;
        logic          fe;
        logic          prev_clear;
        logic          busy_chk;
        logic          have_prev;
        logic [AW-1:0] prev_center;
        int            prev_cyc;
        prev_clear = 1'b0; busy_chk = 1'b0; have_prev = 1'b0; prev_center = '0; prev_cyc = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (busy_chk) begin
                    check("busy_after_frame_done", busy, 0);
                    busy_chk = 1'b0;
                end
                if (write_en) begin
                    if (wr_q.size() == 0) check("write_en_unexpected", write_en, 0);
                    else begin
                        we = wr_q.pop_front();
                        check("wr_addr", wr_addr, we.addr);
                        check("wr_data", pixel_in, we.data);
                        $display("write addr=%o data=0x%02h", wr_addr, pixel_in);
                    end
                end
                if (new_pixel) begin
                    if (np_q.size() == 0) check("new_pixel_unexpected", new_pixel, 0);
                    else begin
                        ne = np_q.pop_front();
                        check("center_addr", center_addr, ne.addr);
                        check("timeout_err_at_center", timeout_err, ne.terr);
                        $display("center=%o timeout_err=%0b", center_addr, timeout_err);
                    end
                    if (silent_en && have_prev && prev_center == silent_addr)
                        check("timeout_gap_cycles", cyc - prev_cyc, TIMEOUT + 1);
                    have_prev = 1'b1; prev_center = center_addr; prev_cyc = cyc;
                end
                if (frame_done) begin
                    if (fr_q.size() == 0) check("frame_done_unexpected", frame_done, 0);
                    else begin
                        fe = fr_q.pop_front();
                        check("timeout_err_at_frame_done", timeout_err, fe);
                    end
                    check("clear_before_frame_done", prev_clear, 1);
                    check("clear_low_in_frame_done", clear, 0);
                    check("busy_in_frame_done", busy, 1);
                    $display("frame_done timeout_err=%0b", timeout_err);
                    busy_chk = 1'b1;
                    have_prev = 1'b0;
                    frames_seen++;
                end
            end
            prev_clear = clear;
        end
    end

    // One frame: push expectations, stream 36 pixels, optionally abort, wait for end.
    task automatic run_frame(input logic [7:0] base, input bit toggle, input bit stray,
                             input bit silent, input bit do_abort, input bit chk_terr_clear);
        logic [IW-1:0] ii;
        logic [JW-1:0] jj;
        int            target;
        int            idx;
        bit            found;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                ii = IW'(i); jj = JW'(j);
                wr_q.push_back({ii, jj, PW'(int'(base) + i * N + j)});
            end
        // Abort frame stops after center {2,4} (index 16); timeout is center {3,2} (index 20).
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                idx = i * N + j;
                ii = IW'(i); jj = JW'(j);
                if (!(do_abort && idx > 16))
                    np_q.push_back({ii, jj, (silent && idx > 20) ? 1'b1 : 1'b0});
            end
        fr_q.push_back(silent);
        silent_en = silent;
        target = frames_seen + 1;

        for (int p = 0; p < M * N; p++) begin
            if (toggle && p > 0) begin
                @(negedge clk);
                s_valid = 1'b0;
                stray_done = (stray && p == 10);
            end
            @(negedge clk);
            stray_done = 1'b0;
            if (p == 1 && chk_terr_clear) check("timeout_err_cleared_first_beat", timeout_err, 0);
            s_valid = 1'b1;
            s_pixel = PW'(int'(base) + p);
        end
        @(negedge clk);
        s_valid = 1'b0;
        check("s_ready_after_last_beat", s_ready, 0);

        if (do_abort) begin
            found = 1'b0;
            for (int c = 0; c < 2000 && !found; c++) begin
                @(negedge clk);
                if (new_pixel && center_addr == 6'o24) found = 1'b1;
            end
            check("abort_target_center_seen", found, 1);
            @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("clear_after_abort", clear, 1);
            @(negedge clk);
            check("frame_done_after_clear", frame_done, 1);
        end

        for (int c = 0; c < 5000 && frames_seen < target; c++) @(negedge clk);
        check("frame_completed", frames_seen, target);
        silent_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with s_valid high: s_ready must stay low and outputs cleared.
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("s_ready_in_reset", s_ready, 0);
        check("outputs_in_reset",
              {write_en, wr_addr, pixel_in, center_addr, new_pixel, clear, busy, frame_done, timeout_err}, 0);
        s_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("s_ready_after_reset", s_ready, 1);
        check("busy_after_reset", busy, 0);

        // Normal frame, back-to-back 0x00..0x23.
        run_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("timeout_err_normal_frame", timeout_err, 0);
        // Core silent on {3,2}.
        run_frame(8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("timeout_err_held_after_frame", timeout_err, 1);
        // Abort on {2,4}; first beat clears the sticky error.
        run_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("busy_after_abort_frame", busy, 0);
        // Gapped stream with a stray core_done during load.
        run_frame(8'hC0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        check("write_queue_drained", wr_q.size(), 0);
        check("center_queue_drained", np_q.size(), 0);
        check("frame_queue_drained", fr_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/eda_pixel_scheduler.md
Name: eda_pixel_scheduler

Overview:
Front-end sequencer for eda_regional_max. It accepts a raster pixel stream through a valid/ready handshake and writes each pixel into the core's image RAM via write_en/wr_addr/pixel_in. It then walks every center address in raster order, pulsing new_pixel and waiting for the core's per-pixel completion before advancing. At end of frame it pulses clear to the core and frame_done to the host.

Parameters:
M, 6, image rows
N, 6, image columns
PIXEL_WIDTH, 8, pixel bit width
I_WIDTH, $clog2(M), row index width
J_WIDTH, $clog2(N), column index width
ADDR_WIDTH, I_WIDTH+J_WIDTH, core address width; address = {i,j}
TIMEOUT, 64, max cycles to wait for core_done per center; 0 disables the timeout
TO_WIDTH, $clog2(TIMEOUT+1), timeout counter width

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
s_valid  in  1  input pixel valid
s_pixel  in  PIXEL_WIDTH  input pixel, raster order (row-major)
s_ready  out  1  block accepts a pixel this cycle
abort  in  1  synchronous frame abort
core_done  in  1  core finished the current center (single-cycle pulse)
write_en  out  1  core RAM write strobe
wr_addr  out  ADDR_WIDTH  core RAM write address {i,j}
pixel_in  out  PIXEL_WIDTH  core RAM write data
center_addr  out  ADDR_WIDTH  current center {i,j} presented to the core
new_pixel  out  1  one-cycle start pulse for center_addr
clear  out  1  one-cycle core clear pulse
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle end-of-frame pulse
timeout_err  out  1  sticky; set on any core_done timeout in the frame

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State goes to IDLE.
  - All registered outputs go to 0, including wr_addr, pixel_in, center_addr and timeout_err.
  - Load and scan counters go to 0.
  - s_ready is 0 while reset_n=0. It is the only combinational output and is 1 in IDLE and LOAD otherwise.
- States: IDLE, LOAD, ISSUE, WAIT, CLEAR, DONE.
- IDLE:
  - The first accepted beat (s_valid & s_ready) moves the state to LOAD.
  - It also clears timeout_err and is written as pixel (0,0).
- Write path:
  - Every accepted beat registers write_en=1, wr_addr={li,lj} and pixel_in=s_pixel. These appear 1 cycle after acceptance.
  - write_en is 0 in any cycle after a non-accept. Back-to-back writes are legal.
  - lj counts 0..N-1. On wrap it returns to 0 and li increments.
- LOAD:
  - The beat at (M-1,N-1) is accepted and the state goes to ISSUE. s_ready is 0 from the next cycle.
  - Scan counters are 0.
- ISSUE:
  - center_addr={ci,cj} is registered and new_pixel=1 for exactly one cycle.
  - The state then goes to WAIT and the timeout counter resets to 0.
- WAIT:
  - center_addr is held stable and new_pixel is 0.
  - On core_done, the scan counter advances in raster order. The state goes to ISSUE, or to CLEAR if the center was (M-1,N-1).
  - If TIMEOUT≠0 and the counter reaches TIMEOUT without core_done:
    - timeout_err is set.
    - The counter advances exactly as on core_done.
  - core_done outside WAIT is ignored.
  - If core_done arrives in the same cycle the timeout is reached, core_done wins and timeout_err is not set.
- CLEAR: clear=1 for one cycle, then DONE.
- DONE: frame_done=1 for one cycle, then IDLE. timeout_err holds until the next frame starts.
- abort:
  - From LOAD, ISSUE or WAIT, the state goes to CLEAR on the next edge. The counters zero and no further writes or new_pixel pulses occur.
  - abort is ignored in IDLE, CLEAR and DONE.
  - abort in the same cycle as an accepted beat: the beat is discarded and write_en stays 0.
- Reset mid-frame: immediate return to IDLE with no clear pulse. The upstream stream restarts at pixel (0,0).
- Width rule: addresses are plain concatenation {i,j}, not i*N+j. Unused codes (i≥M or j≥N) are never produced.

Decomposition:
- Package eda_regional_max_pkg holds:
  - the state enum (sched_state_t);
  - default M, N and PIXEL_WIDTH constants;
  - function make_addr(i,j) returning {i,j}.
- One sub-module, eda_raster_counter, is a parameterized (M,N) i/j counter with inc, clr and last outputs. It is instantiated twice: load position and scan position.

Test Plan:
1. Reset with s_valid=1 → s_ready=0 and all outputs 0. After release, s_ready=1 and busy=0.
2. Stream 36 pixels back-to-back, values 0x00..0x23 → 36 write_en cycles, first wr_addr=6'h00 data 0x00. Pixel 6 gives wr_addr={3'd1,3'd0} data 0x06. Last gives wr_addr={3'd5,3'd5} data 0x23, then s_ready=0.
3. Core model returns core_done 3 cycles after each new_pixel → 36 new_pixel pulses with center_addr {0,0},{0,1},…,{5,5}. Then clear=1 for one cycle, frame_done=1 the next cycle, busy=0, timeout_err=0.
4. Core model never answers on center {3,2}, TIMEOUT=64 → center {3,2} is held 64 cycles in WAIT, then timeout_err=1 and the scan continues at {3,3}. timeout_err stays 1 after frame_done and clears on the next frame's first beat.
5. abort during WAIT on center {2,4} → next cycle clear=1, then frame_done=1, then IDLE. No new_pixel for {2,5}.
6. s_valid toggled every other cycle, plus core_done pulsed during LOAD → write_en is interleaved with zero cycles and addresses stay contiguous. The stray core_done is ignored and the scan still starts at {0,0}.
